// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-memory request/response, decode
// handshake, redirect input and occupancy output.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             dec_valid;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic             dec_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] fq_count;

  // Fetch queue side
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fq_count,
    input  imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fq_count,
    output imem_rdata, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC fetch from a 1-cycle memory,
// DEPTH-entry {pc, instr} FIFO toward decode, redirect squashes everything.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(DEPTH);
  localparam logic [31:0]      PC_STEP = 32'd4;

  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic             inflight_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   occ;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic head_valid;

  // Credit counts the in-flight word as occupied, so a returning response
  // always has a free slot even if decode stalls.
  assign occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue      = !rst && !bus.redirect_valid && (occ < DEPTH_V);
  assign push       = !rst && !bus.redirect_valid && inflight_q;
  assign head_valid = !rst && (count_q != '0);
  assign pop        = head_valid && bus.dec_ready && !bus.redirect_valid;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = head_valid;
  assign bus.dec_pc    = pc_mem[rd_ptr_q];
  assign bus.dec_instr = instr_mem[rd_ptr_q];
  assign bus.fq_count  = count_q;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset, then redirect, then normal issue/push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (bus.redirect_valid) begin
      pc_q       <= bus.redirect_pc & 32'hFFFF_FFFC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        pc_q <= pc_q + PC_STEP;
      end
      inflight_q <= issue;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // PC of the outstanding request, paired with its word when it returns.
  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc_q <= pc_q;
    end
  end

  // FIFO storage; write is already suppressed by reset and redirect.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (RESET_PC 0 and 0xFFFFFFF8) share
// one directed stimulus; a queue-level model checks both every cycle.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus0 ();
  fetch_queue_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.dec_ready      = dec_ready;
  assign bus0.redirect_valid = redirect_valid;
  assign bus0.redirect_pc    = redirect_pc;
  assign bus1.dec_ready      = dec_ready;
  assign bus1.redirect_valid = redirect_valid;
  assign bus1.redirect_pc    = redirect_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Instruction memory contents: instance 0 returns the address, instance 1 a scrambled copy
  function automatic logic [31:0] mem_word(input int i, input logic [31:0] a);
    return (i == 0) ? a : (a ^ 32'h5A5A_0000);
  endfunction

  // One-cycle-latency instruction memories
  always @(posedge clk) begin
    if (bus0.imem_req) bus0.imem_rdata <= mem_word(0, bus0.imem_addr);
    if (bus1.imem_req) bus1.imem_rdata <= mem_word(1, bus1.imem_addr);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: ordered list of buffered {pc, word}, one pending request, next PC
  logic [63:0] mq [2][8];
  int          msz   [2];
  logic [31:0] mpc   [2];
  logic [31:0] mreq  [2];
  bit          minfl [2];
  bit          mok = 1'b0;

  task automatic check_inst(input int i, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [2:0] cnt);
    bit    ereq;
    bit    evld;
    string tag;
    tag  = (i == 0) ? "dut0" : "dut1";
    ereq = !rst && !redirect_valid && (msz[i] + int'(minfl[i]) < DEPTH);
    evld = !rst && (msz[i] > 0);
    chk({tag, "_imem_req"}, {31'b0, req}, {31'b0, ereq});
    chk({tag, "_dec_valid"}, {31'b0, vld}, {31'b0, evld});
    if (mok) begin
      if (ereq) chk({tag, "_imem_addr"}, addr, mpc[i]);
      if (evld) begin
        chk({tag, "_dec_pc"}, pc, mq[i][0][63:32]);
        chk({tag, "_dec_instr"}, ins, mq[i][0][31:0]);
      end
      chk({tag, "_fq_count"}, {29'b0, cnt}, 32'(msz[i]));
    end
  endtask

  task automatic model_step(input int i);
    bit iss;
    if (rst) begin
      msz[i]   = 0;
      minfl[i] = 1'b0;
      mpc[i]   = (i == 0) ? 32'h0 : 32'hFFFF_FFF8;
    end else if (redirect_valid) begin
      msz[i]   = 0;
      minfl[i] = 1'b0;
      mpc[i]   = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      iss = (msz[i] + int'(minfl[i]) < DEPTH);
      if (msz[i] > 0 && dec_ready) begin
        for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
        msz[i]--;
      end
      if (minfl[i]) begin
        mq[i][msz[i]] = {mreq[i], mem_word(i, mreq[i])};
        msz[i]++;
      end
      if (iss) begin
        mreq[i] = mpc[i];
        mpc[i]  = mpc[i] + 32'd4;
      end
      minfl[i] = iss;
    end
  endtask

  // Compare process: check both instances mid-cycle, then advance the model
  initial begin
    forever begin
      @(negedge clk);
      check_inst(0, bus0.imem_req, bus0.imem_addr, bus0.dec_valid,
                 bus0.dec_pc, bus0.dec_instr, bus0.fq_count);
      check_inst(1, bus1.imem_req, bus1.imem_addr, bus1.dec_valid,
                 bus1.dec_pc, bus1.dec_instr, bus1.fq_count);
      model_step(0);
      model_step(1);
      if (rst) mok = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          nreq;
    logic [19:0] pat;
    rst            = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();

    // Streaming from reset with decode always ready
    dec_ready = 1'b1;
    do_reset();
    #1;
    chk("t1_c0_req", {31'b0, bus0.imem_req}, 32'd1);
    chk("t1_c0_addr", bus0.imem_addr, 32'h0);
    chk("t1_c0_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t5_c0_addr", bus1.imem_addr, 32'hFFFF_FFF8);
    tick(); #1;
    chk("t1_c1_addr", bus0.imem_addr, 32'h4);
    chk("t1_c1_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t5_c1_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t1_c2_addr", bus0.imem_addr, 32'h8);
    chk("t1_c2_valid", {31'b0, bus0.dec_valid}, 32'd1);
    chk("t1_c2_pc", bus0.dec_pc, 32'h0);
    chk("t1_c2_instr", bus0.dec_instr, 32'h0);
    chk("t5_c2_addr", bus1.imem_addr, 32'h0);
    chk("t5_c2_pc", bus1.dec_pc, 32'hFFFF_FFF8);
    chk("t5_c2_instr", bus1.dec_instr, 32'hA5A5_FFF8);
    tick(); #1;
    chk("t1_c3_pc", bus0.dec_pc, 32'h4);
    chk("t5_c3_pc", bus1.dec_pc, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t1_c4_pc", bus0.dec_pc, 32'h8);
    chk("t1_c4_count", {29'b0, bus0.fq_count}, 32'd1);
    chk("t5_c4_pc", bus1.dec_pc, 32'h0);
    for (int k = 0; k < 6; k++) tick();

    // Decode stalled from reset: queue fills, then drains in order
    dec_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus0.imem_req) nreq++;
      tick();
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    #1;
    chk("t2_full_count", {29'b0, bus0.fq_count}, 32'd4);
    chk("t2_full_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("t2_head0", bus0.dec_pc, 32'h0);
    dec_ready = 1'b1;
    tick(); #1;
    chk("t2_head4", bus0.dec_pc, 32'h4);
    chk("t2_resume_req", {31'b0, bus0.imem_req}, 32'd1);
    chk("t2_resume_addr", bus0.imem_addr, 32'h10);
    tick(); #1;
    chk("t2_head8", bus0.dec_pc, 32'h8);
    tick(); #1;
    chk("t2_headC", bus0.dec_pc, 32'hC);
    tick(); #1;
    chk("t2_head10", bus0.dec_pc, 32'h10);

    // Redirect while a fetch is in flight
    for (int k = 0; k < 4; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    chk("t3_redir_req", {31'b0, bus0.imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_r1_count", {29'b0, bus0.fq_count}, 32'd0);
    chk("t3_r1_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t3_r1_addr", bus0.imem_addr, 32'h100);
    tick(); #1;
    chk("t3_r2_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t3_r2_addr", bus0.imem_addr, 32'h104);
    tick(); #1;
    chk("t3_r3_valid", {31'b0, bus0.dec_valid}, 32'd1);
    chk("t3_r3_pc", bus0.dec_pc, 32'h100);
    tick(); #1;
    chk("t3_r4_pc", bus0.dec_pc, 32'h104);

    // Redirect to the top of the address space; PC wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3w_r1_addr", bus0.imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t3w_r2_addr", bus0.imem_addr, 32'h0);
    tick(); #1;
    chk("t3w_r3_pc", bus0.dec_pc, 32'hFFFF_FFFC);
    for (int k = 0; k < 3; k++) tick();

    // Half-full queue with simultaneous push/pop across several pointer laps
    dec_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    dec_ready = 1'b1;
    #1;
    chk("t4_count0", {29'b0, bus0.fq_count}, 32'd2);
    chk("t4_pc0", bus0.dec_pc, 32'h0);
    for (int k = 1; k <= 14; k++) begin
      tick(); #1;
      chk("t4_count", {29'b0, bus0.fq_count}, 32'd2);
      chk("t4_pc", bus0.dec_pc, 32'(4 * k));
    end

    // Irregular decode stalls, checked by the model alone
    pat = 20'b1011_0010_1110_0001_1101;
    for (int k = 0; k < 20; k++) begin
      dec_ready = pat[k];
      tick();
    end

    // Reset mid-stream with a full queue of redirected fetches
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #1;
    chk("t6_full_count", {29'b0, bus0.fq_count}, 32'd4);
    chk("t6_full_pc", bus0.dec_pc, 32'h200);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("t6_rst_valid", {31'b0, bus0.dec_valid}, 32'd0);
    tick();
    rst       = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk("t6_post_count", {29'b0, bus0.fq_count}, 32'd0);
    chk("t6_post_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t6_post_addr", bus0.imem_addr, 32'h0);
    tick(); #1;
    chk("t6_p1_valid", {31'b0, bus0.dec_valid}, 32'd0);
    chk("t6_p1_addr", bus0.imem_addr, 32'h4);
    tick(); #1;
    chk("t6_p2_valid", {31'b0, bus0.dec_valid}, 32'd1);
    chk("t6_p2_pc", bus0.dec_pc, 32'h0);
    chk("t6_p2_dut1_pc", bus1.dec_pc, 32'hFFFF_FFF8);
    for (int k = 0; k < 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
